nx_xrfb_reader: RTL

Read-side streaming engine for the NX_XRFB register-file memories (64x18 or 32x36). These memories have an asynchronous read port.
- On a START command, it drives the memory read address (RA) across LEN consecutive locations from BASE.
- It captures the asynchronous read data and delivers it as a valid/ready stream.
- A 2-entry output buffer sustains one word per cycle under backpressure.
- It pairs with the write-port mapping to form the full read path for DMA-style readback of register-file contents.

---
 rtl/nx_xrfb_reader_if.sv | 28 ++
 rtl/nx_xrfb_reader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/nx_xrfb_reader_if.sv
// Command, memory read-port and output-stream signals of the NX_XRFB reader.
interface nx_xrfb_reader_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 18
);
    logic              START;
    logic [ADDR_W-1:0] BASE;
    logic [ADDR_W:0]   LEN;
    logic [ADDR_W-1:0] RA;
    logic [DATA_W-1:0] RD;
    logic [DATA_W-1:0] O_DATA;
    logic              O_VALID;
    logic              O_READY;
    logic              BUSY;
    logic              DONE;

    // Environment side: issues commands, models the memory, consumes the stream
    modport master (
        output START, BASE, LEN, RD, O_READY,
        input  RA, O_DATA, O_VALID, BUSY, DONE
    );

    // Reader side
    modport slave (
        input  START, BASE, LEN, RD, O_READY,
        output RA, O_DATA, O_VALID, BUSY, DONE
    );
endinterface

// File: rtl/nx_xrfb_reader.sv
// Streams LEN consecutive words out of an async-read register file through a
// 2-entry valid/ready buffer, one word per cycle when the sink keeps up.
module nx_xrfb_reader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 18
) (
    input  logic             CK,
    input  logic             R,
    nx_xrfb_reader_if.slave  bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pop;
    logic              push;
    logic [LEN_W-1:0]  len_clamped;

    assign pop = valid_q & bus.O_READY;

    // Command sequencing, address generation and buffer bookkeeping
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rem_d       = rem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        push        = 1'b0;
        len_clamped = (bus.LEN > LEN_MAX) ? LEN_MAX : bus.LEN;

        case (state_q)
            ST_IDLE: begin
                // The DONE cycle still counts as part of the finished command
                if (bus.START && !done_q) begin
                    if (len_clamped != '0) begin
                        ra_d    = bus.BASE;
                        rem_d   = len_clamped;
                        busy_d  = 1'b1;
                        state_d = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if ((rem_q != '0) && ((cnt_q != 2'd2) || pop)) begin
                    push  = 1'b1;
                    ra_d  = ra_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (cnt_q == 2'd1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Head register feeds the stream; tail only holds a word while stalled
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = bus.RD;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = bus.RD;
                end else if (push) begin
                    tail_d = bus.RD;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = bus.RD;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase

        valid_d = (cnt_d != 2'd0);
    end

    // State registers with synchronous reset
    always_ff @(posedge CK) begin
        if (R) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.RA      = ra_q;
    assign bus.O_DATA  = head_q;
    assign bus.O_VALID = valid_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
endmodule
